// File: rtl/candy_seq.sv
`default_nettype none
// ============================================================================
// Module      : candy_seq
// Description : Multi-stage instruction sequencer. Walks a one-hot stage
//               enable through NUM_STAGES stages using per-stage completion
//               handshakes, with stall, flush, halt-at-retire, single-step,
//               per-stage timeout and retire/cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module candy_seq #(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 32,
  localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step_mode,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  halt_req,
  input  logic                  err_clr,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  retire,
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic [CNT_W-1:0]      inst_count,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] c_en_one   = NUM_STAGES'(1);
  localparam logic [31:0]           c_tmo_lim  = 32'(TIMEOUT);
  localparam logic                  c_tmo_en   = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_state_nx;
  logic [IDX_W-1:0] w_idx_nx;
  logic             w_retire_nx;
  logic [CNT_W-1:0] w_inst_nx;
  logic [CNT_W-1:0] w_cyc_nx;
  logic [31:0]      r_tmo;
  logic [31:0]      w_tmo_nx;
  logic             r_halt_pend;
  logic             w_halt_nx;
  logic             w_adv;
  logic             w_last;

  // Next-state, next-output and bookkeeping decode; outputs are registered
  // from these values so everything seen at the ports is flop-driven.
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = stage_idx;
    w_retire_nx = 1'b0;
    w_inst_nx   = inst_count;
    w_tmo_nx    = r_tmo;
    w_halt_nx   = r_halt_pend | (halt_req && (r_state != ST_HALTED));
    w_adv       = (r_state == ST_RUN) && stage_done[stage_idx] && !stall;
    w_last      = (stage_idx == c_last_idx);
    w_cyc_nx    = (r_state == ST_RUN) ? cycle_count + CNT_W'(1) : cycle_count;

    case (r_state)
      ST_IDLE: begin
        if (r_halt_pend) begin
          w_state_nx = ST_HALTED;
          w_halt_nx  = 1'b0;
        end else if (start) begin
          w_state_nx = ST_RUN;
          w_idx_nx   = '0;
          w_tmo_nx   = '0;
        end
      end

      ST_RUN: begin
        if (flush) begin
          // Abandon the instruction: back to stage 0, nothing retires.
          w_idx_nx = '0;
          w_tmo_nx = '0;
        end else if (w_adv) begin
          w_tmo_nx = '0;
          if (!w_last) begin
            w_idx_nx = stage_idx + IDX_W'(1);
          end else begin
            w_retire_nx = 1'b1;
            w_inst_nx   = inst_count + CNT_W'(1);
            w_idx_nx    = '0;
            // A halt request arriving on the retire edge itself still counts.
            if (r_halt_pend || halt_req) begin
              w_state_nx = ST_HALTED;
              w_halt_nx  = 1'b0;
            end else if (step_mode) begin
              w_state_nx = ST_IDLE;
            end
          end
        end else if (!stall && c_tmo_en) begin
          if (r_tmo + 32'd1 == c_tmo_lim) begin
            w_state_nx = ST_ERROR;
            w_tmo_nx   = '0;
          end else begin
            w_tmo_nx = r_tmo + 32'd1;
          end
        end
      end

      ST_HALTED: begin
        w_halt_nx = 1'b0;
        if (start) begin
          w_state_nx = ST_RUN;
          w_idx_nx   = '0;
          w_tmo_nx   = '0;
        end
      end

      ST_ERROR: begin
        // stage_idx keeps the stage that timed out until err_clr.
        if (err_clr) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
        w_idx_nx   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_tmo       <= '0;
      r_halt_pend <= 1'b0;
      stage_en    <= '0;
      stage_idx   <= '0;
      retire      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
      inst_count  <= '0;
      cycle_count <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_tmo       <= w_tmo_nx;
      r_halt_pend <= w_halt_nx;
      stage_en    <= (w_state_nx == ST_RUN) ? (c_en_one << w_idx_nx) : '0;
      stage_idx   <= w_idx_nx;
      retire      <= w_retire_nx;
      busy        <= (w_state_nx == ST_RUN);
      halted      <= (w_state_nx == ST_HALTED);
      err         <= (w_state_nx == ST_ERROR);
      inst_count  <= w_inst_nx;
      cycle_count <= w_cyc_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_candy_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_candy_seq
// Description : Directed self-checking bench for candy_seq (NUM_STAGES=4,
//               TIMEOUT=5). Expected outputs are queued when inputs are
//               driven and popped after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_candy_seq;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, step_mode, stall, flush, halt_req, err_clr;
  logic [3:0]  stage_done;
  logic [3:0]  stage_en;
  logic [1:0]  stage_idx;
  logic        retire, busy, halted, err;
  logic [31:0] inst_count, cycle_count;

  candy_seq #(.NUM_STAGES(4), .TIMEOUT(5), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step_mode  (step_mode),
    .stall      (stall),
    .flush      (flush),
    .halt_req   (halt_req),
    .err_clr    (err_clr),
    .stage_done (stage_done),
    .stage_en   (stage_en),
    .stage_idx  (stage_idx),
    .retire     (retire),
    .busy       (busy),
    .halted     (halted),
    .err        (err),
    .inst_count (inst_count),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  en;
    logic        ret;
    logic [1:0]  st;
    logic [31:0] inst;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] e_inst = 0;
  logic [31:0] e_cyc  = 0;
  logic [1:0]  e_prev = S_IDLE;

  function automatic logic [1:0] oh2idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i[1:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Record what the DUT should show after the next observation point.
  task automatic push_exp(input string tag, input logic [3:0] en, input logic ret,
                          input logic [1:0] st);
    exp_t e;
    if (ret) e_inst = e_inst + 32'd1;
    e.tag = tag; e.en = en; e.ret = ret; e.st = st; e.inst = e_inst; e.cyc = e_cyc;
    sb.push_back(e);
    e_prev = st;
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".en"},     {28'd0, stage_en},    {28'd0, e.en});
    chk({e.tag, ".retire"}, {31'd0, retire},      {31'd0, e.ret});
    chk({e.tag, ".busy"},   {31'd0, busy},        {31'd0, (e.st == S_RUN)});
    chk({e.tag, ".halted"}, {31'd0, halted},      {31'd0, (e.st == S_HALT)});
    chk({e.tag, ".err"},    {31'd0, err},         {31'd0, (e.st == S_ERR)});
    chk({e.tag, ".inst"},   inst_count,           e.inst);
    chk({e.tag, ".cyc"},    cycle_count,          e.cyc);
    if (e.st == S_RUN) chk({e.tag, ".idx"}, {30'd0, stage_idx}, {30'd0, oh2idx(e.en)});
  endtask

  // One clock: cycle_count advances on edges taken while in RUN.
  task automatic step(input string tag, input logic [3:0] en, input logic ret,
                      input logic [1:0] st);
    if (e_prev == S_RUN) e_cyc = e_cyc + 32'd1;
    push_exp(tag, en, ret, st);
    @(posedge clk); #1;
    pop_cmp();
  endtask

  task automatic now_chk(input string tag, input logic [3:0] en, input logic ret,
                         input logic [1:0] st);
    push_exp(tag, en, ret, st);
    pop_cmp();
  endtask

  initial begin
    rst = 1'b0; start = 0; step_mode = 0; stall = 0; flush = 0;
    halt_req = 0; err_clr = 0; stage_done = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    now_chk("reset", 4'b0000, 0, S_IDLE);
    chk("reset.idx", {30'd0, stage_idx}, 32'd0);
    step("idle_hold", 4'b0000, 0, S_IDLE);

    // Full pass through all four stages, then continue at stage 0.
    start = 1; step("start", 4'b0001, 0, S_RUN);
    start = 0;
    stage_done = 4'b0001; step("adv0", 4'b0010, 0, S_RUN);
    stage_done = 4'b0010; step("adv1", 4'b0100, 0, S_RUN);
    stage_done = 4'b0100; step("adv2", 4'b1000, 0, S_RUN);
    stage_done = 4'b1000; step("retire1", 4'b0001, 1, S_RUN);
    // Done bits of other stages are ignored.
    stage_done = 4'b1110; step("ignore", 4'b0001, 0, S_RUN);
    stage_done = 4'b0001; step("adv0b", 4'b0010, 0, S_RUN);
    stage_done = 4'b0010; step("adv1b", 4'b0100, 0, S_RUN);

    // Stage 2: 2 idle + 3 stalled + 2 idle = 4 counted cycles, below TIMEOUT.
    stage_done = 4'b0000; step("idle2a", 4'b0100, 0, S_RUN);
    step("idle2b", 4'b0100, 0, S_RUN);
    stall = 1; stage_done = 4'b0100;
    step("stall1", 4'b0100, 0, S_RUN);
    step("stall2", 4'b0100, 0, S_RUN);
    step("stall3", 4'b0100, 0, S_RUN);
    stall = 0; stage_done = 4'b0000;
    step("idle2c", 4'b0100, 0, S_RUN);
    step("idle2d", 4'b0100, 0, S_RUN);
    stage_done = 4'b0100; step("release", 4'b1000, 0, S_RUN);

    // Flush beats a simultaneous final-stage completion.
    flush = 1; stage_done = 4'b1000; step("flush", 4'b0001, 0, S_RUN);
    flush = 0;

    // Timeout at stage 1 after five unstalled cycles.
    stage_done = 4'b0001; step("to_s1", 4'b0010, 0, S_RUN);
    stage_done = 4'b0000;
    step("wait1", 4'b0010, 0, S_RUN);
    step("wait2", 4'b0010, 0, S_RUN);
    step("wait3", 4'b0010, 0, S_RUN);
    step("wait4", 4'b0010, 0, S_RUN);
    step("timeout", 4'b0000, 0, S_ERR);
    start = 1; step("err_start", 4'b0000, 0, S_ERR);
    start = 0; err_clr = 1; step("err_clr", 4'b0000, 0, S_IDLE);
    err_clr = 0; start = 1; step("restart", 4'b0001, 0, S_RUN);
    start = 0;

    // Halt request pulsed at stage 1 takes effect at retire.
    stage_done = 4'b0001; step("h_s1", 4'b0010, 0, S_RUN);
    halt_req = 1; stage_done = 4'b0010; step("h_req", 4'b0100, 0, S_RUN);
    halt_req = 0; stage_done = 4'b0100; step("h_s3", 4'b1000, 0, S_RUN);
    stage_done = 4'b1000; step("h_retire", 4'b0000, 1, S_HALT);
    stage_done = 4'b0000; step("h_hold", 4'b0000, 0, S_HALT);
    start = 1; step("h_start", 4'b0001, 0, S_RUN);
    start = 0;

    // Single-step: back to IDLE after the retire.
    step_mode = 1;
    stage_done = 4'b0001; step("st_s1", 4'b0010, 0, S_RUN);
    stage_done = 4'b0010; step("st_s2", 4'b0100, 0, S_RUN);
    stage_done = 4'b0100; step("st_s3", 4'b1000, 0, S_RUN);
    stage_done = 4'b1000; step("st_retire", 4'b0000, 1, S_IDLE);
    stage_done = 4'b0000; step("st_idle", 4'b0000, 0, S_IDLE);
    step_mode = 0;

    // Halt latched in IDLE moves to HALTED one cycle later.
    halt_req = 1; step("ih_latch", 4'b0000, 0, S_IDLE);
    halt_req = 0; step("ih_halt", 4'b0000, 0, S_HALT);
    start = 1; step("ih_start", 4'b0001, 0, S_RUN);
    start = 0;

    // Asynchronous reset at stage 2.
    stage_done = 4'b0001; step("r_s1", 4'b0010, 0, S_RUN);
    stage_done = 4'b0010; step("r_s2", 4'b0100, 0, S_RUN);
    stage_done = 4'b0100;
    rst = 1'b0;
    #2;
    e_inst = 0; e_cyc = 0; e_prev = S_IDLE;
    now_chk("async_rst", 4'b0000, 0, S_IDLE);
    chk("async_rst.idx", {30'd0, stage_idx}, 32'd0);
    step("rst_hold", 4'b0000, 0, S_IDLE);
    rst = 1'b1;
    step("post_rst", 4'b0000, 0, S_IDLE);
    stage_done = 4'b0000;
    start = 1; step("post_start", 4'b0001, 0, S_RUN);
    start = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/candy_seq.md
CANDY_SEQ -- requirements
Module: candy_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_STAGES, 4, number of sequenced stages (legal 2..8).
- TIMEOUT, 255, per-stage cycle limit before error (0 disables timeout).
- CNT_W, 32, width of the retire and cycle counters.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, leave IDLE and begin at stage 0.
- step_mode, in, 1, 1 = return to IDLE after each retire.
- stall, in, 1, freeze stage advance and timeout count.
- flush, in, 1, abandon current instruction, restart at stage 0.
- halt_req, in, 1, request stop at next retire boundary.
- err_clr, in, 1, leave ERROR back to IDLE.
- stage_done, in, NUM_STAGES, per-stage completion handshake.
- stage_en, out, NUM_STAGES, one-hot enable of the active stage.
- stage_idx, out, clog2(NUM_STAGES), index of the active stage.
- retire, out, 1, one-cycle pulse when the last stage completes.
- busy, out, 1, high in RUN.
- halted, out, 1, high in HALTED.
- err, out, 1, high in ERROR.
- inst_count, out, CNT_W, retired-instruction count.
- cycle_count, out, CNT_W, cycles spent in RUN.

Function
REQ-003 States: IDLE, RUN, HALTED, ERROR; all outputs registered.
REQ-004 IDLE: stage_en=0; start=1 -> RUN with stage_idx=0 and stage_en[0]=1 on the next cycle.
REQ-005 RUN: stage_en SHALL be exactly one-hot at bit stage_idx, held until the stage advances.
REQ-006 Advance on edge where stage_done[stage_idx]=1 and stall=0; stage_done bits of other stages are ignored.
REQ-007 Advance from k<NUM_STAGES-1 -> k+1 next cycle; no idle gap between stages.
REQ-008 Advance from NUM_STAGES-1 -> retire=1 for exactly one cycle, inst_count+1 (wraps modulo 2^CNT_W), then:
- halt pending: HALTED.
- step_mode=1: IDLE.
- otherwise: stage 0 in RUN.
REQ-009 flush=1 in RUN -> stage_idx=0 next cycle, no retire, no inst_count change; flush wins over a simultaneous advance.
REQ-010 halt_req is latched when seen in any state other than HALTED; the latch clears on entry to HALTED. In IDLE a latched halt moves to HALTED on the next cycle.
REQ-011 HALTED: stage_en=0, counters frozen; start=1 -> RUN at stage 0 with the halt latch clear.
REQ-012 Timeout counter:
- cleared on every stage change, flush, or entry to RUN.
- increments each RUN cycle with stall=0 and no advance.
- reaching TIMEOUT (TIMEOUT!=0) -> ERROR next cycle.
- an advance in the same cycle wins over the timeout.
REQ-013 ERROR: stage_en=0, err=1; stays until err_clr=1 -> IDLE; start is ignored.
REQ-014 cycle_count increments every cycle state==RUN, including stalled cycles; wraps modulo 2^CNT_W.
REQ-015 Priority in RUN: flush > advance > timeout.
REQ-016 busy, halted and err are mutually exclusive; all three are 0 in IDLE.

Reset
REQ-017 rst low asynchronously forces:
- state=IDLE, stage_en=0, stage_idx=0, retire=0, busy=halted=err=0.
- inst_count=0, cycle_count=0, timeout counter=0, halt latch=0.
REQ-018 Reset asserted mid-RUN abandons the instruction with no retire pulse; first RUN after release requires start.

Verification
REQ-019 NUM_STAGES=4: start, stage_done of the active stage asserted each cycle -> stage_en 0001,0010,0100,1000, retire on cycle 5, inst_count=1, continues at 0001.
REQ-020 stall=1 for 3 cycles while stage 2 done=1 -> stage_en holds 0100, no timeout increment, cycle_count +3; release -> advance.
REQ-021 flush and stage_done[3] asserted together at stage 3 -> stage 0 next cycle, retire=0, inst_count unchanged.
REQ-022 TIMEOUT=5, stage 1 never done -> err=1 after 5 unstalled cycles, stage_en=0; err_clr -> IDLE; start -> stage 0.
REQ-023 halt_req pulsed at stage 1 -> runs to retire, then halted=1, stage_en=0; start -> RUN at stage 0. step_mode=1 -> IDLE after each retire.
REQ-024 rst low at stage 2 -> all outputs at reset values immediately, counters 0, no retire pulse.
